// File: rtl/spram_pkg.sv
// Shared types and helpers for the SPRAM controller and its power sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spram_pkg;

    localparam int SPRAM_AW = 14;  // SPRAM primitive address width
    localparam int SPRAM_DW = 16;  // SPRAM primitive data width

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        STBY   = 2'd1,
        SLEEP  = 2'd2,
        WAKE   = 2'd3
    } pwr_state_e;

    // MASKWREN gates writes per nibble, so each byte enable covers two mask bits.
    function automatic logic [7:0] be_to_mask(input logic [3:0] be);
        logic [7:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[2*b +: 2] = {2{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/spram_pwr_fsm.sv
// SPRAM power sequencer: idle-driven STANDBY, requested SLEEP, timed wake-up.
// Latency: state changes take effect one cycle after the triggering condition.
// Backpressure: ready_gate is low outside ACTIVE and while sleep_req is high.
// Ports: clk/rst_n; req_valid (pending request), accept (request taken this cycle),
//        sleep_req (level); standby/sleep to the SPRAMs, ready_gate to the bus.
module spram_pwr_fsm
    import spram_pkg::*;
#(
    parameter int IDLE_CYCLES     = 16,
    parameter int WAKE_SB_CYCLES  = 1,
    parameter int WAKE_SLP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic accept,
    input  logic sleep_req,
    output logic standby,
    output logic sleep,
    output logic ready_gate
);

    localparam int IW   = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
    localparam int WMAX = (WAKE_SB_CYCLES > WAKE_SLP_CYCLES) ? WAKE_SB_CYCLES : WAKE_SLP_CYCLES;
    localparam int WW   = (WMAX > 1) ? $clog2(WMAX + 1) : 1;

    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_SB   = WW'(WAKE_SB_CYCLES);
    localparam logic [WW-1:0] WAKE_SLP  = WW'(WAKE_SLP_CYCLES);

    pwr_state_e    state;
    logic [IW-1:0] idle_cnt;
    logic [WW-1:0] wake_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACTIVE;
            idle_cnt <= '0;
            wake_cnt <= '0;
        end else begin
            case (state)
                ACTIVE: begin
                    // ready_gate is withheld while sleep_req is high, so no new
                    // access can be in flight; the last response is already on
                    // the bus in this cycle.
                    if (sleep_req) begin
                        state    <= SLEEP;
                        idle_cnt <= '0;
                    end else if (accept) begin
                        idle_cnt <= '0;
                    end else if (IDLE_CYCLES != 0 && idle_cnt == IDLE_LAST) begin
                        state    <= STBY;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                STBY: begin
                    if (req_valid || sleep_req) begin
                        state    <= WAKE;
                        wake_cnt <= WAKE_SB;
                    end
                end
                SLEEP: begin
                    if (!sleep_req) begin
                        state    <= WAKE;
                        wake_cnt <= WAKE_SLP;
                    end
                end
                WAKE: begin
                    // WAKE lasts wake_cnt cycles (minimum one).
                    if (wake_cnt <= WW'(1)) begin
                        state <= ACTIVE;
                    end else begin
                        wake_cnt <= wake_cnt - WW'(1);
                    end
                end
                default: state <= ACTIVE;
            endcase
        end
    end

    assign standby    = (state == STBY) || (state == SLEEP);
    assign sleep      = (state == SLEEP);
    assign ready_gate = (state == ACTIVE) && !sleep_req;

endmodule

// File: rtl/spram_ctrl.sv
// 32-bit valid/ready front end driving 1 or 2 banks of paired iCE40 SPRAMs.
// Latency: response (read data or write ack) exactly one cycle after accept.
// Backpressure: req_ready drops only for power states; responses cannot stall.
// Ports: clk/rst_n; req_* request stream; rsp_valid/rsp_rdata response;
//        sleep_req/sleep_ack power handshake; spram_* drive the SPRAM primitives.
// Macro SPRAM_CTRL_PWR_EN enables the power sequencer; undefined = always ACTIVE.
module spram_ctrl
    import spram_pkg::*;
#(
    parameter int BANKS_DEEP      = 1,
    parameter int ADDR_W          = 13 + BANKS_DEEP,
    parameter int IDLE_CYCLES     = 16,
    parameter int WAKE_SB_CYCLES  = 1,
    parameter int WAKE_SLP_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [31:0]             req_wdata,
    input  logic [3:0]              req_be,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_rdata,
    input  logic                    sleep_req,
    output logic                    sleep_ack,
    output logic [SPRAM_AW-1:0]     spram_addr,
    output logic [2*SPRAM_DW-1:0]   spram_datain,
    output logic [7:0]              spram_maskwren,
    output logic                    spram_wren,
    output logic [BANKS_DEEP-1:0]   spram_cs,
    output logic                    spram_standby,
    output logic                    spram_sleep,
    output logic                    spram_poweroff,
    input  logic [32*BANKS_DEEP-1:0] spram_dataout
);

    logic        accept;
    logic        bank;
    logic        bank_q;
    logic        rsp_rd_q;
    logic [31:0] bank_rdata [BANKS_DEEP];

    assign accept = req_valid && req_ready;
    assign bank   = (BANKS_DEEP == 2) ? req_addr[ADDR_W-1] : 1'b0;

    // The SPRAM registers these on the same edge that accepts the request.
    assign spram_addr     = req_addr[SPRAM_AW-1:0];
    assign spram_datain   = req_wdata;
    assign spram_maskwren = be_to_mask(req_be);
    assign spram_wren     = accept && req_we;
    assign spram_poweroff = 1'b1;

    always_comb begin
        spram_cs = '0;
        for (int i = 0; i < BANKS_DEEP; i++) begin
            spram_cs[i] = accept && (bank == 1'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rd_q  <= 1'b0;
            bank_q    <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_rd_q  <= accept && !req_we;
            if (accept) begin
                bank_q <= bank;
            end
        end
    end

    for (genvar g = 0; g < BANKS_DEEP; g++) begin : g_unpack
        assign bank_rdata[g] = spram_dataout[32*g +: 32];
    end

    // DATAOUT is valid in the cycle after the access, so mux it straight out.
    always_comb begin
        rsp_rdata = '0;
        if (rsp_rd_q) begin
            rsp_rdata = bank_rdata[bank_q];
        end
    end

`ifdef SPRAM_CTRL_PWR_EN
    logic ready_gate;

    spram_pwr_fsm #(
        .IDLE_CYCLES     (IDLE_CYCLES),
        .WAKE_SB_CYCLES  (WAKE_SB_CYCLES),
        .WAKE_SLP_CYCLES (WAKE_SLP_CYCLES)
    ) u_pwr_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .accept     (accept),
        .sleep_req  (sleep_req),
        .standby    (spram_standby),
        .sleep      (spram_sleep),
        .ready_gate (ready_gate)
    );

    assign req_ready = ready_gate;
    assign sleep_ack = spram_sleep;
`else
    logic unused_sleep_req;
    assign unused_sleep_req = sleep_req;

    assign req_ready     = 1'b1;
    assign spram_standby = 1'b0;
    assign spram_sleep   = 1'b0;
    assign sleep_ack     = 1'b0;
`endif

endmodule

// File: tb/tb_spram_ctrl.sv
// Directed bench for spram_ctrl (two banks) with a behavioural SPRAM model.
// Power-state scenarios are exercised when SPRAM_CTRL_PWR_EN is defined;
// otherwise the bench checks that the block never leaves ACTIVE.
module tb_spram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [14:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        sleep_req;
    logic        sleep_ack;
    logic [13:0] spram_addr;
    logic [31:0] spram_datain;
    logic [7:0]  spram_maskwren;
    logic        spram_wren;
    logic [1:0]  spram_cs;
    logic        spram_standby;
    logic        spram_sleep;
    logic        spram_poweroff;
    logic [63:0] spram_dataout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spram_ctrl #(
        .BANKS_DEEP      (2),
        .IDLE_CYCLES     (16),
        .WAKE_SB_CYCLES  (1),
        .WAKE_SLP_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_be         (req_be),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .sleep_req      (sleep_req),
        .sleep_ack      (sleep_ack),
        .spram_addr     (spram_addr),
        .spram_datain   (spram_datain),
        .spram_maskwren (spram_maskwren),
        .spram_wren     (spram_wren),
        .spram_cs       (spram_cs),
        .spram_standby  (spram_standby),
        .spram_sleep    (spram_sleep),
        .spram_poweroff (spram_poweroff),
        .spram_dataout  (spram_dataout)
    );

    // Behavioural SPRAM pair per bank: nibble-masked writes, registered reads.
    logic [31:0] mem [2][16384];

    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (spram_cs[b]) begin
                if (spram_wren) begin
                    for (int n = 0; n < 8; n++) begin
                        if (spram_maskwren[n]) mem[b][spram_addr][4*n +: 4] <= spram_datain[4*n +: 4];
                    end
                end else begin
                    spram_dataout[32*b +: 32] <= mem[b][spram_addr];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Any access must happen with both low-power controls released.
    always @(negedge clk) begin
        if (rst_n && spram_cs != 2'b00) begin
            check("cs_in_lowpower", {30'b0, spram_standby, spram_sleep}, 32'h0);
        end
    end

    // Issue one request, wait (bounded) for acceptance, check drive and response.
    task automatic do_req(input string tag, input logic we, input logic [14:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [7:0] exp_mask, input logic [31:0] exp_rdata);
        int waited = 0;
        logic [1:0] exp_cs;
        exp_cs    = addr[14] ? 2'b10 : 2'b01;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_accept_in_time"}, 32'(waited < 50), 32'h1);
        check({tag, "_cs"}, 32'(spram_cs), 32'(exp_cs));
        check({tag, "_wren"}, 32'(spram_wren), 32'(we));
        check({tag, "_addr"}, 32'(spram_addr), 32'(addr[13:0]));
        if (we) check({tag, "_mask"}, 32'(spram_maskwren), 32'(exp_mask));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
        check({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        sleep_req = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_cs", 32'(spram_cs), 32'h0);
        check("rst_wren", 32'(spram_wren), 32'h0);
        check("rst_standby", 32'(spram_standby), 32'h0);
        check("rst_sleep", 32'(spram_sleep), 32'h0);
        check("rst_poweroff", 32'(spram_poweroff), 32'h1);
        check("rst_sleep_ack", 32'(sleep_ack), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: full-word write then read back
        do_req("t1_wr", 1'b1, 15'h0005, 32'hDEADBEEF, 4'hF, 8'hFF, 32'h0);
        do_req("t1_rd", 1'b0, 15'h0005, 32'h0, 4'h0, 8'h00, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        check("t1_rsp_pulse", 32'(rsp_valid), 32'h0);

        // 2: partial byte write
        do_req("t2_wr_full", 1'b1, 15'h0010, 32'h11223344, 4'hF, 8'hFF, 32'h0);
        do_req("t2_wr_byte1", 1'b1, 15'h0010, 32'h0000AA00, 4'h2, 8'h0C, 32'h0);
        do_req("t2_rd", 1'b0, 15'h0010, 32'h0, 4'h0, 8'h00, 32'h1122AA44);

        // 3: two banks, same SPRAM address, back-to-back reads
        do_req("t3_wr_b0", 1'b1, 15'h0000, 32'hA5A50001, 4'hF, 8'hFF, 32'h0);
        do_req("t3_wr_b1", 1'b1, 15'h4000, 32'h5A5A0002, 4'hF, 8'hFF, 32'h0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 15'h0000;
        @(negedge clk);
        check("t3_b2b_ready", 32'(req_ready), 32'h1);
        check("t3_b2b_cs0", 32'(spram_cs), 32'h1);
        @(posedge clk);
        #1;
        req_addr = 15'h4000;
        check("t3_b2b_rsp0_valid", 32'(rsp_valid), 32'h1);
        check("t3_b2b_rsp0_data", rsp_rdata, 32'hA5A50001);
        @(negedge clk);
        check("t3_b2b_cs1", 32'(spram_cs), 32'h2);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("t3_b2b_rsp1_valid", 32'(rsp_valid), 32'h1);
        check("t3_b2b_rsp1_data", rsp_rdata, 32'h5A5A0002);

`ifdef SPRAM_CTRL_PWR_EN
        // 4: auto-standby after 16 idle cycles, wake on request
        repeat (15) @(posedge clk);
        #1;
        check("t4_idle15_standby", 32'(spram_standby), 32'h0);
        check("t4_idle15_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        check("t4_idle16_standby", 32'(spram_standby), 32'h1);
        check("t4_idle16_ready", 32'(req_ready), 32'h0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 15'h0010;
        @(negedge clk);
        check("t4_stby_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        check("t4_wake_standby", 32'(spram_standby), 32'h0);
        check("t4_wake_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        check("t4_active_ready", 32'(req_ready), 32'h1);
        check("t4_active_cs", 32'(spram_cs), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("t4_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t4_rsp_data", rsp_rdata, 32'h1122AA44);

        // 5: sleep requested while a read is outstanding
        req_valid = 1'b1;
        req_addr  = 15'h4000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sleep_req = 1'b1;
        check("t5_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t5_rsp_data", rsp_rdata, 32'h5A5A0002);
        check("t5_sleep_before", 32'(spram_sleep), 32'h0);
        check("t5_ready_gated", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        check("t5_sleep", 32'(spram_sleep), 32'h1);
        check("t5_sleep_ack", 32'(sleep_ack), 32'h1);
        check("t5_sleep_standby", 32'(spram_standby), 32'h1);
        check("t5_rsp_gone", 32'(rsp_valid), 32'h0);
        req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t5_sleep_no_cs", 32'(spram_cs), 32'h0);
        check("t5_sleep_ready", 32'(req_ready), 32'h0);
        req_valid = 1'b0;
        sleep_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t5_wake4_ready", 32'(req_ready), 32'h0);
        check("t5_wake4_sleep", 32'(spram_sleep), 32'h0);
        check("t5_wake4_ack", 32'(sleep_ack), 32'h0);
        @(posedge clk);
        #1;
        check("t5_wake5_ready", 32'(req_ready), 32'h1);
`else
        // Without the power sequencer the block never leaves ACTIVE.
        repeat (20) @(posedge clk);
        #1;
        check("np_idle_standby", 32'(spram_standby), 32'h0);
        check("np_idle_ready", 32'(req_ready), 32'h1);
        sleep_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("np_sleep_ignored", 32'(spram_sleep), 32'h0);
        check("np_sleep_ack", 32'(sleep_ack), 32'h0);
        check("np_sleep_ready", 32'(req_ready), 32'h1);
        do_req("np_rd_in_sleep", 1'b0, 15'h4000, 32'h0, 4'h0, 8'h00, 32'h5A5A0002);
        sleep_req = 1'b0;
`endif

        // 6: asynchronous reset with a response pending
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 15'h0000;
        @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("t6_rsp_before_rst", 32'(rsp_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("t6_rst_rsp_rdata", rsp_rdata, 32'h0);
        check("t6_rst_cs", 32'(spram_cs), 32'h0);
        check("t6_rst_wren", 32'(spram_wren), 32'h0);
        check("t6_rst_standby", 32'(spram_standby), 32'h0);
        check("t6_rst_sleep", 32'(spram_sleep), 32'h0);
        check("t6_rst_poweroff", 32'(spram_poweroff), 32'h1);
        check("t6_rst_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rsp_dropped", 32'(rsp_valid), 32'h0);
        do_req("t6_rd_after_rst", 1'b0, 15'h0005, 32'h0, 4'h0, 8'h00, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
